pp_column_loader: RTL and testbench

PP_COLUMN_LOADER -- requirements
Module: pp_column_loader

---
 rtl/pp_loader_pkg.sv | 42 ++++
 rtl/pp_column_loader_shreg.sv | 44 ++++
 rtl/pp_column_loader.sv | 150 +++++++++++++++
 tb/tb_pp_column_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pp_loader_pkg.sv
// pp_loader_pkg
// Shared definitions for the partial-product column loader:
//   - loader_state_e : FSM state encoding (FILL, SETTLE, DONE)
//   - col_height     : number of partial-product bits in column c of an n x n product
//   - col_offset     : bit position of column c inside the flattened pp_bits bus
//   - dst_width      : width of the compressor result for an n-bit operand
//   - LAT_W          : width of the compressor latency counter (latency 0..15)
package pp_loader_pkg;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } loader_state_e;

   localparam int LAT_W = 4;

   // Columns grow by one bit up to the middle column, then shrink again.
   function automatic int col_height(input int n, input int c);
      int up;
      int down;
      up   = c + 1;
      down = 2 * n - 1 - c;
      return (up < down) ? up : down;
   endfunction

   // Columns are packed back to back, lowest column first.
   function automatic int col_offset(input int n, input int c);
      int sum;
      sum = 0;
      for (int k = 0; k < c; k++) begin
         sum += col_height(n, k);
      end
      return sum;
   endfunction

   // A full n x n product plus one guard bit from the redundant compressor output.
   function automatic int dst_width(input int n);
      return 2 * n + 1;
   endfunction

endpackage

// File: rtl/pp_column_loader_shreg.sv
// pp_col_shreg
// One partial-product column: an H-bit shift register fed serially at bit 0.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset, clears the column
//   clear    - synchronous flush, wins over shift_en
//   shift_en - shift the column by one position
//   din      - serial input bit, enters at bit 0
//   q        - column contents, bit 0 is the most recent bit
module pp_col_shreg #(
   parameter int H = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         shift_en,
   input  logic         din,
   output logic [H-1:0] q
);

   // A single-bit column has nothing to shift; it just reloads from din.
   if (H == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q <= '0;
         end else if (clear) begin
            q <= '0;
         end else if (shift_en) begin
            q <= din;
         end
      end
   end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q <= '0;
         end else if (clear) begin
            q <= '0;
         end else if (shift_en) begin
            q <= {q[H-2:0], din};
         end
      end
   end

endmodule

// File: rtl/pp_column_loader.sv
// pp_column_loader
// Serially loads the partial-product columns of an N x N multiplier, presents
// them flattened to an external compressor, and captures the compressor result
// once the columns are full and the inputs have been quiet for the
// compressor's latency.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   src_ser   - one serial bit per column, indexed by column
//   shift_en  - shift every column by one position
//   clear     - synchronous flush of columns, fill count and result
//   pp_bits   - all columns flattened, column c at col_offset(N,c)
//   fill_cnt  - saturating number of shifts since reset/clear
//   full      - fill_cnt has reached N
//   comp_dst  - compressor result for the current pp_bits
//   res       - captured compressor result
//   res_valid - one-cycle pulse when res updates
module pp_column_loader
   import pp_loader_pkg::*;
#(
   parameter int  N        = 30,
   parameter int  COMP_LAT = 0,
   localparam int NCOL     = 2 * N - 1,
   localparam int TOTAL    = N * N,
   localparam int DSTW     = dst_width(N),
   localparam int CNTW     = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCOL-1:0]  src_ser,
   input  logic             shift_en,
   input  logic             clear,
   output logic [TOTAL-1:0] pp_bits,
   output logic [CNTW-1:0]  fill_cnt,
   output logic             full,
   input  logic [DSTW-1:0]  comp_dst,
   output logic [DSTW-1:0]  res,
   output logic             res_valid
);

   localparam logic [CNTW-1:0]  N_CNT    = CNTW'(N);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(COMP_LAT);

   loader_state_e    state;
   loader_state_e    state_next;
   logic [LAT_W-1:0] lat_cnt;
   logic [LAT_W-1:0] lat_next;
   logic             capture;

   // Column registers, each mapped straight onto its slice of pp_bits.
   for (genvar c = 0; c < NCOL; c++) begin : g_col
      localparam int H   = col_height(N, c);
      localparam int OFF = col_offset(N, c);
      logic [H-1:0] col_q;

      pp_col_shreg #(
         .H(H)
      ) u_col (
         .clk      (clk),
         .rst_n    (rst_n),
         .clear    (clear),
         .shift_en (shift_en),
         .din      (src_ser[c]),
         .q        (col_q)
      );

      assign pp_bits[OFF +: H] = col_q;
   end

   // full is kept as its own register so it never depends combinationally
   // on fill_cnt; it is set on the shift that brings fill_cnt to N.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_cnt <= '0;
         full     <= 1'b0;
      end else if (clear) begin
         fill_cnt <= '0;
         full     <= 1'b0;
      end else if (shift_en && (fill_cnt != N_CNT)) begin
         fill_cnt <= fill_cnt + 1'b1;
         full     <= (fill_cnt == (N_CNT - 1'b1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FILL;
         lat_cnt <= '0;
      end else if (clear) begin
         state   <= FILL;
         lat_cnt <= '0;
      end else begin
         state   <= state_next;
         lat_cnt <= lat_next;
      end
   end

   // Any shift means pp_bits changed, so a pending or completed capture is
   // stale and the loader falls back to FILL. A capture only happens after
   // the columns have been full and untouched for the whole latency window.
   always_comb begin
      state_next = state;
      lat_next   = lat_cnt;
      capture    = 1'b0;
      case (state)
         FILL: begin
            if (full && !shift_en) begin
               state_next = SETTLE;
               lat_next   = LAT_INIT;
            end
         end
         SETTLE: begin
            if (shift_en) begin
               state_next = FILL;
            end else if (lat_cnt != '0) begin
               lat_next = lat_cnt - 1'b1;
            end else begin
               capture    = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (shift_en) begin
               state_next = FILL;
            end
         end
         default: begin
            state_next = FILL;
         end
      endcase
   end

   // res_valid follows capture by one register stage; capture moves the FSM
   // to DONE, so it can never be asserted two cycles in a row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res       <= '0;
         res_valid <= 1'b0;
      end else if (clear) begin
         res       <= '0;
         res_valid <= 1'b0;
      end else begin
         res_valid <= capture;
         if (capture) begin
            res <= comp_dst;
         end
      end
   end

endmodule

// File: tb/tb_pp_column_loader.sv
// tb_pp_column_loader
// Self-checking bench for pp_column_loader with N=4, COMP_LAT=2.
// A behavioural model keeps each column as a list of recent serial bits and
// predicts capture from the number of quiet cycles since the columns filled.
module tb_pp_column_loader;

   localparam int N        = 4;
   localparam int COMP_LAT = 2;
   localparam int NCOL     = 2 * N - 1;
   localparam int TOTAL    = N * N;
   localparam int DSTW     = 2 * N + 1;
   localparam int CNTW     = $clog2(N + 1);

   logic             clk;
   logic             rst_n;
   logic [NCOL-1:0]  src_ser;
   logic             shift_en;
   logic             clear;
   logic [TOTAL-1:0] pp_bits;
   logic [CNTW-1:0]  fill_cnt;
   logic             full;
   logic [DSTW-1:0]  comp_dst;
   logic [DSTW-1:0]  res;
   logic             res_valid;

   int assertCount;
   int failCount;

   // Reference model state
   bit               colHist [NCOL][N];
   int               expFill;
   int               idleRun;
   logic [DSTW-1:0]  expRes;
   bit               expValid;

   pp_column_loader #(
      .N        (N),
      .COMP_LAT (COMP_LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_ser   (src_ser),
      .shift_en  (shift_en),
      .clear     (clear),
      .pp_bits   (pp_bits),
      .fill_cnt  (fill_cnt),
      .full      (full),
      .comp_dst  (comp_dst),
      .res       (res),
      .res_valid (res_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int heightOf(input int c);
      return (c + 1 < 2 * N - 1 - c) ? c + 1 : 2 * N - 1 - c;
   endfunction

   function automatic logic [TOTAL-1:0] expPp();
      logic [TOTAL-1:0] v;
      int pos;
      v   = '0;
      pos = 0;
      for (int c = 0; c < NCOL; c++) begin
         for (int i = 0; i < heightOf(c); i++) begin
            v[pos + i] = colHist[c][i];
         end
         pos += heightOf(c);
      end
      return v;
   endfunction

   task automatic modelReset();
      for (int c = 0; c < NCOL; c++) begin
         for (int i = 0; i < N; i++) begin
            colHist[c][i] = 1'b0;
         end
      end
      expFill  = 0;
      idleRun  = 0;
      expRes   = '0;
      expValid = 1'b0;
   endtask

   // One clock edge of the model: a capture happens on the edge that completes
   // COMP_LAT+2 consecutive quiet cycles after the columns became full.
   task automatic modelStep(input bit sh, input logic [NCOL-1:0] src,
                            input bit clr, input logic [DSTW-1:0] dst);
      if (clr) begin
         modelReset();
      end else begin
         expValid = 1'b0;
         if (sh) begin
            for (int c = 0; c < NCOL; c++) begin
               for (int i = heightOf(c) - 1; i > 0; i--) begin
                  colHist[c][i] = colHist[c][i-1];
               end
               colHist[c][0] = src[c];
            end
            if (expFill < N) expFill++;
            idleRun = 0;
         end else if (expFill == N) begin
            idleRun++;
            if (idleRun == COMP_LAT + 2) begin
               expValid = 1'b1;
               expRes   = dst;
            end
         end
      end
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkAll();
      checkOutput("pp_bits", 64'(pp_bits), 64'(expPp()));
      checkOutput("fill_cnt", 64'(fill_cnt), 64'(expFill));
      checkOutput("full", 64'(full), 64'(expFill == N));
      checkOutput("res", 64'(res), 64'(expRes));
      checkOutput("res_valid", 64'(res_valid), 64'(expValid));
   endtask

   // Drive one cycle of inputs, advance the model on the same edge, then
   // sample the DUT 1 ns after the edge.
   task automatic applyStimulus(input bit sh, input logic [NCOL-1:0] src,
                                input bit clr, input logic [DSTW-1:0] dst);
      shift_en = sh;
      src_ser  = src;
      clear    = clr;
      comp_dst = dst;
      @(posedge clk);
      modelStep(sh, src, clr, dst);
      #1;
      checkAll();
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      rst_n    = 1'b0;
      shift_en = 1'b0;
      clear    = 1'b0;
      src_ser  = '0;
      comp_dst = '0;
      modelReset();

      repeat (2) @(posedge clk);
      #1;
      checkAll();
      checkOutput("reset_pp", 64'(pp_bits), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // All-ones fill, then one extra shift to hit saturation
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 7'h7F, 1'b0, '0);
      checkOutput("ones_pp", 64'(pp_bits), 64'hFFFF);
      checkOutput("ones_full", 64'(full), 64'h1);
      checkOutput("ones_cnt", 64'(fill_cnt), 64'd4);
      applyStimulus(1'b1, 7'h7F, 1'b0, '0);
      checkOutput("sat_cnt", 64'(fill_cnt), 64'd4);

      // Single bit into column 0; the one-bit column reloads on the next shift
      applyStimulus(1'b0, 7'h00, 1'b1, '0);
      applyStimulus(1'b1, 7'h01, 1'b0, '0);
      checkOutput("bit0_pp", 64'(pp_bits), 64'h0001);
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 7'h00, 1'b0, '0);
      checkOutput("bit0_gone", 64'(pp_bits), 64'h0000);

      // Quiet cycles after full: pulse on the 4th edge after the last shift
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(1'b0, 7'h00, 1'b0, 9'h0A5);
         checkOutput("cap_valid", 64'(res_valid), 64'(k == 4));
      end
      checkOutput("cap_res", 64'(res), 64'h0A5);

      // Shift during SETTLE aborts the capture; the next one takes full latency
      applyStimulus(1'b1, 7'h55, 1'b0, 9'h1C3);
      applyStimulus(1'b0, 7'h00, 1'b0, 9'h1C3);
      applyStimulus(1'b0, 7'h00, 1'b0, 9'h1C3);
      applyStimulus(1'b1, 7'h2A, 1'b0, 9'h1C3);
      checkOutput("abort_valid", 64'(res_valid), 64'h0);
      checkOutput("abort_res", 64'(res), 64'h0A5);
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1'b0, 7'h00, 1'b0, 9'h1C3);
         checkOutput("recap_valid", 64'(res_valid), 64'(k == 4));
      end
      checkOutput("recap_res", 64'(res), 64'h1C3);

      // clear beats a simultaneous shift
      applyStimulus(1'b1, 7'h7F, 1'b1, 9'h1FF);
      checkOutput("clr_pp", 64'(pp_bits), 64'h0);
      checkOutput("clr_cnt", 64'(fill_cnt), 64'h0);
      checkOutput("clr_res", 64'(res), 64'h0);

      // Asynchronous reset while in SETTLE
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 7'h7F, 1'b0, 9'h0F0);
      applyStimulus(1'b0, 7'h00, 1'b0, 9'h0F0);
      applyStimulus(1'b0, 7'h00, 1'b0, 9'h0F0);
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("arst_pp", 64'(pp_bits), 64'h0);
      checkOutput("arst_cnt", 64'(fill_cnt), 64'h0);
      checkOutput("arst_full", 64'(full), 64'h0);
      checkOutput("arst_res", 64'(res), 64'h0);
      checkOutput("arst_valid", 64'(res_valid), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b0, 7'h00, 1'b0, 9'h0F0);
         checkOutput("arst_novalid", 64'(res_valid), 64'h0);
      end

      // Randomized traffic against the model
      for (int k = 0; k < 600; k++) begin
         applyStimulus(($urandom_range(0, 2) == 0),
                       NCOL'($urandom),
                       ($urandom_range(0, 49) == 0),
                       DSTW'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
